// File: rtl/lift_eq2_collector_pkg.sv
// Shared lift constants and types.
// Provides residue width, lane pitch, lane count, packet lengths per mode,
// the packed FIFO entry type and a helper that maps mode to packet length.
package lift_eq2_collector_pkg;

    localparam int LIFT_W       = 30;
    localparam int LIFT_SLOT    = 32;
    localparam int LIFT_LANES   = 7;
    localparam int LIFT_N_MODE1 = 6;
    localparam int LIFT_N_MODE0 = 7;
    localparam int LIFT_DATA_W  = LIFT_SLOT * LIFT_LANES;

    typedef struct packed {
        logic [2:0]             lanes;
        logic [LIFT_DATA_W-1:0] data;
    } lift_pkt_t;

    function automatic logic [2:0] lift_pkt_len(input logic mode);
        return mode ? 3'(LIFT_N_MODE1) : 3'(LIFT_N_MODE0);
    endfunction

endpackage

// File: rtl/lift_eq2_collector_if.sv
// Packet output port of the equation-2 collector.
//   out_data   packet, lane k at [SLOT*k +: W]
//   out_lanes  residue count in the packet
//   out_valid  head packet available
//   out_ready  consumer accepts the head packet
// master: collector side, slave: lift memory writer side.
interface lift_eq2_collector_if;
    import lift_eq2_collector_pkg::*;

    logic [LIFT_DATA_W-1:0] out_data;
    logic [2:0]             out_lanes;
    logic                   out_valid;
    logic                   out_ready;

    modport master (output out_data, output out_lanes, output out_valid, input out_ready);
    modport slave  (input out_data, input out_lanes, input out_valid, output out_ready);

endinterface

// File: rtl/lift_pkt_fifo.sv
// Packet FIFO with a registered head.
//   clock, reset  clock, synchronous active-high reset
//   push, din     enqueue request and packet
//   pop           dequeue the head (ignored when empty)
//   full, empty   occupancy flags
//   head          registered head packet, holds its last value when empty
//   head_valid    head holds a queued packet
// A push while full is accepted only if a pop happens in the same cycle.
module lift_pkt_fifo
    import lift_eq2_collector_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  lift_pkt_t din,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output lift_pkt_t head,
    output logic      head_valid
);

    localparam int PW = $clog2(DEPTH);

    lift_pkt_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_next;
    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        rd_next    = do_pop ? rd_ptr + PW'(1) : rd_ptr;
        count_next = count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // The head is reloaded from the entry that will be at the read pointer after
    // this edge; if that entry is being written right now, take it from din.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr     <= rd_next;
            count      <= count_next;
            head_valid <= (count_next != '0);
            if (count_next != '0) begin
                head <= (do_push && (wr_ptr == rd_next)) ? din : mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/lift_eq2_collector.sv
// Collects the serial residue stream of the equation-2 lift stage into one
// parallel packet per coefficient (6 residues when mode=1, 7 when mode=0) and
// buffers packets for the lift memory writer.
//   clock, reset  clock, synchronous active-high reset
//   mode          packet length select, latched on the first residue
//   q_in          residue, q_valid_in marks it valid
//   out_if        packet valid/ready port (master side)
//   busy          a packet is partially assembled
//   overflow      sticky: a completed packet was dropped on a full buffer
module lift_eq2_collector
    import lift_eq2_collector_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mode,
    input  logic [LIFT_W-1:0] q_in,
    input  logic              q_valid_in,
    lift_eq2_collector_if.master out_if,
    output logic              busy,
    output logic              overflow
);

    logic [2:0]             idx;
    logic                   mode_lat;
    logic [LIFT_DATA_W-1:0] asm_reg;
    logic [LIFT_DATA_W-1:0] asm_next;
    logic [2:0]             n_cur;
    logic                   commit;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    lift_pkt_t              push_pkt;
    lift_pkt_t              head;
    logic                   head_valid;

    // On the first residue the live mode input decides the length, since the
    // latched copy is only written on that same edge.
    always_comb begin
        n_cur    = (idx == 3'd0) ? lift_pkt_len(mode) : lift_pkt_len(mode_lat);
        asm_next = asm_reg;
        if (q_valid_in) begin
            asm_next[LIFT_SLOT*32'(idx) +: LIFT_W] = q_in;
        end
        commit         = q_valid_in && (idx == n_cur - 3'd1);
        push_pkt.lanes = n_cur;
        push_pkt.data  = asm_next;
    end

    assign pop  = !fifo_empty && out_if.out_ready;
    assign busy = (idx != 3'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            idx      <= '0;
            mode_lat <= 1'b0;
            asm_reg  <= '0;
            overflow <= 1'b0;
        end else begin
            if (q_valid_in) begin
                if (idx == 3'd0) begin
                    mode_lat <= mode;
                end
                if (commit) begin
                    idx     <= '0;
                    asm_reg <= '0;
                end else begin
                    idx     <= idx + 3'd1;
                    asm_reg <= asm_next;
                end
            end
            if (commit && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    lift_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (commit),
        .din        (push_pkt),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (head),
        .head_valid (head_valid)
    );

    assign out_if.out_data  = head.data;
    assign out_if.out_lanes = head.lanes;
    assign out_if.out_valid = head_valid;

endmodule

// File: tb/tb_lift_eq2_collector.sv
module tb_lift_eq2_collector;
    import lift_eq2_collector_pkg::*;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mode = 1'b0;
    logic [29:0] q_in = '0;
    logic        q_valid_in = 1'b0;
    logic        busy;
    logic        overflow;

    lift_eq2_collector_if out_if ();

    lift_eq2_collector #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .mode       (mode),
        .q_in       (q_in),
        .q_valid_in (q_valid_in),
        .out_if     (out_if),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    // reference model state
    lift_pkt_t   exp_q [$];
    logic [29:0] cur [$];
    int          cur_n = 7;
    int          mcnt = 0;
    bit          movf = 0;
    lift_pkt_t   last_pkt = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advances the model by one clock edge using the inputs the bench drove.
    task automatic model_step();
        bit        pop;
        bit        acc;
        lift_pkt_t p;
        if (reset) begin
            cur.delete();
            exp_q.delete();
            mcnt     = 0;
            movf     = 0;
            last_pkt = '0;
            return;
        end
        pop = (mcnt > 0) && out_if.out_ready;
        acc = 0;
        if (q_valid_in) begin
            if (cur.size() == 0) cur_n = mode ? 6 : 7;
            cur.push_back(q_in);
            if (cur.size() == cur_n) begin
                p = '0;
                p.lanes = 3'(cur_n);
                for (int i = 0; i < cur_n; i++) p.data[32*i +: 30] = cur[i];
                cur.delete();
                if (mcnt < DEPTH || pop) begin
                    exp_q.push_back(p);
                    acc = 1;
                end else begin
                    movf = 1;
                end
            end
        end
        mcnt = mcnt - int'(pop) + int'(acc);
    endtask

    task automatic cyc(input bit v, input logic [29:0] q, input bit md, input bit rdy, input bit rst = 0);
        @(negedge clock);
        reset            = rst;
        q_valid_in       = v;
        q_in             = q;
        mode             = md;
        out_if.out_ready = rdy;
        @(posedge clock);
        #1;
        model_step();
    endtask

    task automatic send(input int n, input logic [29:0] base, input int step, input bit md,
                        input bit rdy, input bit rdy_last);
        for (int i = 0; i < n; i++)
            cyc(1, base + 30'(step * i), md, (i == n - 1) ? rdy_last : rdy);
    endtask

    task automatic idle(input int k, input bit rdy);
        for (int i = 0; i < k; i++) cyc(0, '0, 0, rdy);
    endtask

    // monitor / scoreboard
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (mon_en) begin
                chk("out_valid", 256'(out_if.out_valid), 256'(mcnt > 0));
                chk("overflow", 256'(overflow), 256'(movf));
                chk("busy", 256'(busy), 256'(cur.size() != 0));
                if (out_if.out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_packet actual=%0h required=none", out_if.out_data);
                    end else begin
                        chk("head_data", 256'(out_if.out_data), 256'(exp_q[0].data));
                        chk("head_lanes", 256'(out_if.out_lanes), 256'(exp_q[0].lanes));
                        if (out_if.out_ready) last_pkt = exp_q.pop_front();
                    end
                end else begin
                    chk("idle_data", 256'(out_if.out_data), 256'(last_pkt.data));
                    chk("idle_lanes", 256'(out_if.out_lanes), 256'(last_pkt.lanes));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        out_if.out_ready = 1'b0;
        cyc(0, '0, 0, 0, 1);
        cyc(0, '0, 0, 0, 1);
        chk("reset_data", 256'(out_if.out_data), 256'd0);
        chk("reset_lanes", 256'(out_if.out_lanes), 256'd0);
        chk("reset_valid", 256'(out_if.out_valid), 256'd0);
        chk("reset_ovf", 256'(overflow), 256'd0);
        mon_en = 1;

        // 1: six residues 1..6
        send(6, 30'd1, 1, 1, 1, 1);
        idle(3, 1);
        // 2: seven residues counting down from all-ones
        send(7, 30'h3FFFFFFF, -1, 0, 1, 1);
        idle(3, 1);
        // 3: three packets while stalled, third dropped
        send(6, 30'd10, 1, 1, 0, 0);
        send(6, 30'd20, 1, 1, 0, 0);
        send(6, 30'd30, 1, 1, 0, 0);
        idle(2, 0);
        chk("t3_overflow", 256'(overflow), 256'd1);
        idle(4, 1);
        cyc(0, '0, 0, 0, 1);
        // 4: pop coincides with the third commit
        send(6, 30'd40, 1, 1, 0, 0);
        send(6, 30'd50, 1, 1, 0, 0);
        send(6, 30'd60, 1, 1, 0, 1);
        idle(5, 1);
        chk("t4_overflow", 256'(overflow), 256'd0);
        // 5: reset mid-packet
        send(3, 30'd70, 1, 1, 1, 1);
        cyc(0, '0, 0, 0, 1);
        send(6, 30'd80, 1, 1, 1, 1);
        idle(3, 1);
        // 6: mode change mid-packet ignored, next packet uses new mode
        cyc(1, 30'd90, 1, 1);
        cyc(1, 30'd91, 1, 1);
        send(4, 30'd92, 1, 0, 1, 1);
        send(7, 30'd100, 1, 0, 1, 1);
        idle(3, 1);
        chk("t6_lanes", 256'(out_if.out_lanes), 256'd7);

        // randomized traffic with gaps, stalls and occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0)
                cyc(0, '0, 0, 0, 1);
            else
                cyc($urandom_range(0, 9) < 7, 30'($urandom), 1'($urandom), $urandom_range(0, 1) == 1);
        end
        idle(6, 1);
        chk("drain", 256'(exp_q.size()), 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
